// File: rtl/nrf24_spi_pkg.sv
// Shared definitions for the nRF24L01 SPI transaction sequencer: state encoding,
// transfer limits and the radio command opcodes used by the command FSM.
package nrf24_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } nrf_state_e;

  localparam int         NRF_MAX_XFER_BYTES = 33;
  localparam logic [7:0] NRF_CMD_NOP        = 8'hFF;
  localparam logic [7:0] NRF_CMD_W_REGISTER = 8'h20;
  localparam logic [7:0] NRF_CMD_R_REGISTER = 8'h00;

  // Command byte plus at most 32 payload bytes; zero-length requests are meaningless.
  function automatic logic nrf_count_ok(input logic [5:0] n);
    return (n != 6'd0) && (n <= 6'(NRF_MAX_XFER_BYTES));
  endfunction

endpackage

// File: rtl/spi_sck_edge_gen.sv
// Half-period counter that runs only while enabled and marks where SCK should
// rise and fall; it restarts from a clean low phase every time it is re-enabled.
module spi_sck_edge_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_rise,
  output logic o_fall
);

  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV / 2 - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_last;

  assign w_last = i_en && (r_cnt == HALF_LAST);
  assign o_rise = w_last && !r_phase;
  assign o_fall = w_last && r_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_last) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/nrf24_spi_xfer_ctrl.sv
// SPI mode-0 master that frames one nRF24L01 command (1..33 bytes) under CSN,
// pulling bytes from the command FSM and returning each MISO byte as it completes.
module nrf24_spi_xfer_ctrl
  import nrf24_spi_pkg::*;
#(
  parameter int CLK_DIV   = 10,
  parameter int CSN_SETUP = 2,
  parameter int CSN_HOLD  = 2,
  parameter int CSN_GAP   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] byte_count,
  output logic       busy,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       done,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_csn,
  output logic [2:0] o_dbg_state
);

  localparam int TMAX = (CSN_SETUP > CSN_HOLD) ?
                        ((CSN_SETUP > CSN_GAP) ? CSN_SETUP : CSN_GAP) :
                        ((CSN_HOLD > CSN_GAP) ? CSN_HOLD : CSN_GAP);
  localparam int TW = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] SETUP_LAST = TW'(CSN_SETUP - 1);
  localparam logic [TW-1:0] HOLD_LAST  = TW'(CSN_HOLD - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(CSN_GAP - 1);

  nrf_state_e    r_state;
  logic [TW-1:0] r_tcnt;
  logic [5:0]    r_remaining;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shreg;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_done;
  logic          r_busy;
  logic          r_tx_ready;
  logic          r_sck;
  logic          r_mosi;
  logic          r_csn;
  logic          w_rise;
  logic          w_fall;

  spi_sck_edge_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_edge_gen (
    .clk    (clk),
    .reset  (reset),
    .i_en   (r_state == ST_SHIFT),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_tcnt      <= '0;
      r_remaining <= '0;
      r_bit_cnt   <= '0;
      r_shreg     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
      r_csn       <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && nrf_count_ok(byte_count)) begin
            r_state     <= ST_SETUP;
            r_csn       <= 1'b0;
            r_busy      <= 1'b1;
            r_remaining <= byte_count;
            r_tcnt      <= '0;
          end
        end
        ST_SETUP: begin
          if (r_tcnt == SETUP_LAST) begin
            r_tcnt     <= '0;
            r_state    <= ST_LOAD;
            r_tx_ready <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_LOAD: begin
          if (tx_valid) begin
            r_shreg    <= tx_data;
            r_mosi     <= tx_data[7];
            r_tx_ready <= 1'b0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // After each rise shreg[7] already holds the next bit to present on MOSI.
          if (w_rise) begin
            r_sck   <= 1'b1;
            r_shreg <= {r_shreg[6:0], spi_miso};
          end else if (w_fall) begin
            r_sck     <= 1'b0;
            r_mosi    <= r_shreg[7];
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_rx_data  <= r_shreg;
              r_rx_valid <= 1'b1;
              if (r_remaining != 6'd0) begin
                r_remaining <= r_remaining - 1'b1;
              end
              if (r_remaining <= 6'd1) begin
                r_state <= ST_HOLD;
              end else begin
                r_state    <= ST_LOAD;
                r_tx_ready <= 1'b1;
              end
            end
          end
        end
        ST_HOLD: begin
          if (r_tcnt == HOLD_LAST) begin
            r_tcnt  <= '0;
            r_csn   <= 1'b1;
            r_state <= ST_GAP;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_tcnt == GAP_LAST) begin
            r_tcnt  <= '0;
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign tx_ready    = r_tx_ready;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign done        = r_done;
  assign spi_sck     = r_sck;
  assign spi_mosi    = r_mosi;
  assign spi_csn     = r_csn;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nrf24_spi_xfer_ctrl.sv
// Bench for the nRF24 SPI sequencer: a mode-0 slave model plus a per-cycle
// monitor that checks framing, data and status against transaction-level rules.
module tb_nrf24_spi_xfer_ctrl;
  import nrf24_spi_pkg::*;

  localparam int CLK_DIV   = 4;
  localparam int CSN_SETUP = 2;
  localparam int CSN_HOLD  = 2;
  localparam int CSN_GAP   = 5;
  localparam int H         = CLK_DIV / 2;

  typedef struct {
    int n;
    int exp_low;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (CLK_DIV=4) ----------------
  logic       start, busy, tx_valid, tx_ready, rx_valid, done;
  logic       spi_sck, spi_mosi, spi_miso, spi_csn;
  logic [5:0] byte_count;
  logic [7:0] tx_data, rx_data;
  logic [2:0] dbg_state;

  nrf24_spi_xfer_ctrl #(
    .CLK_DIV(CLK_DIV), .CSN_SETUP(CSN_SETUP), .CSN_HOLD(CSN_HOLD), .CSN_GAP(CSN_GAP)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .byte_count(byte_count), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .done(done), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_csn(spi_csn), .o_dbg_state(dbg_state)
  );

  // ---------------- second DUT (CLK_DIV=2) ----------------
  logic       start2, busy2, txv2, tx_ready2, rx_valid2, done2;
  logic       sck2, mosi2, miso2, csn2;
  logic [5:0] bc2;
  logic [7:0] txd2, rx_data2;
  logic [2:0] dbg2;

  nrf24_spi_xfer_ctrl #(
    .CLK_DIV(2), .CSN_SETUP(CSN_SETUP), .CSN_HOLD(CSN_HOLD), .CSN_GAP(CSN_GAP)
  ) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .byte_count(bc2), .busy(busy2),
    .tx_data(txd2), .tx_valid(txv2), .tx_ready(tx_ready2), .rx_data(rx_data2),
    .rx_valid(rx_valid2), .done(done2), .spi_sck(sck2), .spi_mosi(mosi2),
    .spi_miso(miso2), .spi_csn(csn2), .o_dbg_state(dbg2)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  logic [7:0] miso_q[$];
  txn_t       txn_q[$];
  logic [7:0] t_tx[33];
  logic [7:0] t_rx[33];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- monitor + slave model ----------------
  int         cyc = 0;
  int         since_rise = 1000;
  int         low_cnt = 0, sck_rises = 0, hi_run = 0, mosi_bits = 0;
  int         last_low_len = 0, last_sck_rises = 0, last_rise_cyc = 0, last_fall_cyc = 0;
  int         done_cnt = 0, rx_cnt = 0;
  logic       prev_csn = 1'b1, prev_sck = 1'b0, cur_valid = 1'b0;
  logic [7:0] mosi_acc = 8'h00, last_mosi = 8'h00, last_rx = 8'h00;
  logic [7:0] slave_byte = 8'h00;
  logic [2:0] slave_bit = 3'd7;
  txn_t       cur;

  initial spi_miso = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_csn = 1'b1; prev_sck = 1'b0; cur_valid = 1'b0;
      since_rise = 1000; mosi_bits = 0; hi_run = 0;
      slave_byte = 8'h00; slave_bit = 3'd7; spi_miso = 1'b0;
      exp_tx_q.delete(); exp_rx_q.delete(); miso_q.delete(); txn_q.delete();
    end else begin
      if (prev_csn && !spi_csn) begin
        last_fall_cyc = cyc; low_cnt = 0; sck_rises = 0; mosi_bits = 0;
        if (txn_q.size() == 0) begin
          chk("unexpected_csn_fall", 32'd1, 32'd0);
          cur_valid = 1'b0;
        end else begin
          cur = txn_q.pop_front();
          cur_valid = 1'b1;
        end
        slave_byte = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
        slave_bit  = 3'd7;
      end
      if (!prev_csn && spi_csn) begin
        last_rise_cyc = cyc; since_rise = 0;
        last_low_len = low_cnt; last_sck_rises = sck_rises;
        if (cur_valid) begin
          chk("csn_low_len", low_cnt, cur.exp_low);
          chk("sck_pulses", sck_rises, 8 * cur.n);
        end
        cur_valid = 1'b0;
      end else if (since_rise < 1000) begin
        since_rise++;
      end
      if (!spi_csn) low_cnt++;

      if (!prev_sck && spi_sck) begin
        sck_rises++; hi_run = 0;
        mosi_acc = {mosi_acc[6:0], spi_mosi};
        mosi_bits++;
        if (mosi_bits == 8) begin
          mosi_bits = 0; last_mosi = mosi_acc;
          if (exp_tx_q.size() == 0) chk("mosi_unexpected_byte", 32'd1, 32'd0);
          else chk("mosi_byte", mosi_acc, exp_tx_q.pop_front());
        end
      end
      if (prev_sck && !spi_sck) begin
        chk("sck_high_time", hi_run, H);
        if (slave_bit == 3'd0) begin
          slave_byte = (miso_q.size() != 0) ? miso_q.pop_front() : 8'h00;
          slave_bit  = 3'd7;
        end else begin
          slave_bit = slave_bit - 3'd1;
        end
      end
      if (spi_sck) hi_run++;
      spi_miso = slave_byte[slave_bit];

      if (rx_valid) begin
        rx_cnt++; last_rx = rx_data;
        if (exp_rx_q.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
        else chk("rx_data", rx_data, exp_rx_q.pop_front());
      end
      if (done) done_cnt++;
      chk("busy", busy, 32'((!spi_csn) || (since_rise < CSN_GAP)));
      chk("done", done, 32'(spi_csn && (since_rise == CSN_GAP)));
      if (spi_csn) chk("sck_idle_csn_high", spi_sck, 32'd0);
      prev_csn = spi_csn; prev_sck = spi_sck;
    end
  end

  // Slave and counters for the CLK_DIV=2 instance (fixed NOP response 0x0E).
  int         s2_low = 0, s2_rises = 0, s2_rxcnt = 0;
  logic       p2_csn = 1'b1, p2_sck = 1'b0;
  logic [2:0] s2_bit = 3'd7;
  logic [7:0] s2_byte = 8'h0E, s2_mosi = 8'h00, s2_rx = 8'h00;

  initial miso2 = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      p2_csn = 1'b1; p2_sck = 1'b0; s2_bit = 3'd7; miso2 = 1'b0;
    end else begin
      if (p2_csn && !csn2) begin s2_low = 0; s2_rises = 0; s2_bit = 3'd7; end
      if (!csn2) s2_low++;
      if (!p2_sck && sck2) begin s2_rises++; s2_mosi = {s2_mosi[6:0], mosi2}; end
      if (p2_sck && !sck2) s2_bit = s2_bit - 3'd1;
      if (rx_valid2) begin s2_rx = rx_data2; s2_rxcnt++; end
      miso2 = s2_byte[s2_bit];
      p2_csn = csn2; p2_sck = sck2;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(output bit ok);
    for (int k = 0; k < 200; k++) begin
      if (tx_ready) begin ok = 1'b1; return; end
      @(posedge clk); #1;
    end
    chk("tx_ready_timeout", 32'd0, 32'd1);
    ok = 1'b0;
  endtask

  task automatic run_xfer(input int n, input int stall_idx, input int stall_load,
                          input bit hold_start, input bit poke, input bit abort);
    bit   ok;
    int   extra;
    int   r;
    logic p;
    txn_t t;
    extra = (stall_idx >= 0 && stall_idx < n) ? stall_load - 1 : 0;
    t.n = n;
    t.exp_low = CSN_SETUP + CSN_HOLD + n * (1 + 8 * CLK_DIV) + extra;
    txn_q.push_back(t);
    for (int i = 0; i < n; i++) begin
      exp_tx_q.push_back(t_tx[i]);
      miso_q.push_back(t_rx[i]);
      exp_rx_q.push_back(t_rx[i]);
    end
    start = 1'b1; byte_count = 6'(n);
    @(posedge clk); #1;
    start = hold_start;
    for (int i = 0; i < n; i++) begin
      if (i == stall_idx) begin
        tx_valid = 1'b0;
        wait_ready(ok);
        if (!ok) return;
        repeat (stall_load - 1) begin @(posedge clk); #1; end
      end
      tx_data = t_tx[i]; tx_valid = 1'b1;
      wait_ready(ok);
      if (!ok) return;
      @(posedge clk); #1;
      if (poke && i == 0) begin
        start = 1'b1; byte_count = 6'd5;
        @(posedge clk); #1;
        start = hold_start; byte_count = 6'(n);
      end
      if (abort) begin
        r = 0; p = spi_sck;
        for (int k = 0; k < 100 && r < 3; k++) begin
          @(posedge clk); #1;
          if (spi_sck && !p) r++;
          p = spi_sck;
        end
        chk("abort_rises_seen", r, 3);
        reset = 1'b1; #1;
        chk("abort_csn", spi_csn, 32'd1);
        chk("abort_sck", spi_sck, 32'd0);
        chk("abort_busy", busy, 32'd0);
        repeat (3) @(posedge clk);
        #1; reset = 1'b0; tx_valid = 1'b0;
        return;
      end
    end
    tx_valid = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk); #1;
      if (done) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  int d0, rx0, r1, n, sidx;

  initial begin
    reset = 1'b1; start = 1'b0; byte_count = 6'd0; tx_data = 8'h00; tx_valid = 1'b0;
    start2 = 1'b0; bc2 = 6'd0; txd2 = 8'h00; txv2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csn", spi_csn, 32'd1);
    chk("rst_sck", spi_sck, 32'd0);
    chk("rst_mosi", spi_mosi, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_tx_ready", tx_ready, 32'd0);
    chk("rst_rx_valid", rx_valid, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_rx_data", rx_data, 32'd0);
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // NOP: one byte out, status 0x0E back.
    t_tx[0] = NRF_CMD_NOP; t_rx[0] = 8'h0E;
    d0 = done_cnt; rx0 = rx_cnt;
    run_xfer(1, -1, 1, 1'b0, 1'b0, 1'b0);
    chk("nop_rx", last_rx, 32'h0E);
    chk("nop_mosi", last_mosi, 32'hFF);
    chk("nop_csn_low", last_low_len, 32'd37);
    chk("nop_sck_pulses", last_sck_rises, 32'd8);
    chk("nop_done_count", done_cnt - d0, 32'd1);
    chk("nop_rx_count", rx_cnt - rx0, 32'd1);

    // W_REGISTER with both bytes presented early.
    t_tx[0] = NRF_CMD_W_REGISTER; t_tx[1] = 8'h0B;
    t_rx[0] = 8'h0E; t_rx[1] = 8'(($urandom));
    rx0 = rx_cnt;
    run_xfer(2, -1, 1, 1'b0, 1'b0, 1'b0);
    chk("wreg_csn_low", last_low_len, 32'd70);
    chk("wreg_mosi_last", last_mosi, 32'h0B);
    chk("wreg_rx_count", rx_cnt - rx0, 32'd2);

    // Stall before the second byte: ten LOAD cycles.
    t_tx[0] = NRF_CMD_R_REGISTER; t_tx[1] = 8'hA5; t_rx[0] = 8'h3C; t_rx[1] = 8'hC3;
    run_xfer(2, 1, 10, 1'b0, 1'b0, 1'b0);
    chk("stall_csn_low", last_low_len, 32'd79);
    chk("stall_rx_last", last_rx, 32'hC3);

    // Ignored starts: while busy, and with out-of-range counts in IDLE.
    for (int i = 0; i < 3; i++) begin t_tx[i] = 8'($urandom); t_rx[i] = 8'($urandom); end
    d0 = done_cnt;
    run_xfer(3, -1, 1, 1'b0, 1'b1, 1'b0);
    chk("poke_done_count", done_cnt - d0, 32'd1);
    d0 = done_cnt;
    start = 1'b1; byte_count = 6'd0;
    @(posedge clk); #1;
    byte_count = 6'd34;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("ignored_busy", busy, 32'd0);
    chk("ignored_csn", spi_csn, 32'd1);
    chk("ignored_done_count", done_cnt - d0, 32'd0);

    // Reset after the third SCK rise of byte 1.
    for (int i = 0; i < 2; i++) begin t_tx[i] = 8'($urandom); t_rx[i] = 8'($urandom); end
    d0 = done_cnt; rx0 = rx_cnt;
    run_xfer(2, -1, 1, 1'b0, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_done_count", done_cnt - d0, 32'd0);
    chk("abort_rx_count", rx_cnt - rx0, 32'd0);
    for (int i = 0; i < 3; i++) begin t_tx[i] = 8'($urandom); t_rx[i] = 8'($urandom); end
    d0 = done_cnt;
    run_xfer(3, -1, 1, 1'b0, 1'b0, 1'b0);
    chk("post_abort_done_count", done_cnt - d0, 32'd1);

    // Back-to-back with start held high.
    t_tx[0] = NRF_CMD_NOP; t_rx[0] = 8'h0E;
    run_xfer(1, -1, 1, 1'b1, 1'b0, 1'b0);
    r1 = last_rise_cyc;
    t_tx[0] = 8'($urandom); t_tx[1] = 8'($urandom); t_rx[0] = 8'($urandom); t_rx[1] = 8'($urandom);
    run_xfer(2, -1, 1, 1'b0, 1'b0, 1'b0);
    chk("b2b_csn_gap", last_fall_cyc - r1, CSN_GAP + 1);

    // Randomized transactions.
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 33);
      for (int i = 0; i < n; i++) begin t_tx[i] = 8'($urandom); t_rx[i] = 8'($urandom); end
      sidx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      d0 = done_cnt;
      run_xfer(n, sidx, $urandom_range(2, 6), 1'b0, 1'b0, 1'b0);
      chk("rand_done_count", done_cnt - d0, 32'd1);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    // CLK_DIV=2 instance runs the NOP case.
    txd2 = NRF_CMD_NOP; txv2 = 1'b1; start2 = 1'b1; bc2 = 6'd1;
    @(posedge clk); #1;
    start2 = 1'b0;
    r1 = 0;
    for (int k = 0; k < 200 && r1 == 0; k++) begin
      @(posedge clk); #1;
      if (done2) r1 = 1;
    end
    chk("div2_done_seen", r1, 32'd1);
    chk("div2_csn_low", s2_low, 32'd21);
    chk("div2_sck_pulses", s2_rises, 32'd8);
    chk("div2_mosi", s2_mosi, 32'hFF);
    chk("div2_rx", s2_rx, 32'h0E);
    chk("div2_rx_count", s2_rxcnt, 32'd1);
    txv2 = 1'b0;

    repeat (3) begin @(posedge clk); #1; end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
